// File: rtl/decoder_ctrl_pkg.sv
// Shared types and defaults for the decoder sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_ctrl_pkg;

    localparam int DEF_LEN   = 512;  // pattern length, matches decoder512 depth
    localparam int DEF_CNT_W = 16;   // saturating match counter width
    localparam int DEF_BC_W  = 10;   // program bit counter width, 2^BC_W > LEN

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PROGRAM = 2'd2,
        DETECT  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/decoder512.sv
// Serial pattern matcher: LEN-bit program register and LEN-bit signal window.
// Latency: out is combinational from the two registers (one clock after the last shift).
// Backpressure: none; the signal window shifts every clock, the pattern only when enable=1.
//
// Ports:
//   clk    - rising-edge clock
//   clr    - synchronous clear of both registers
//   enable - shift prgm into the pattern register
//   prgm   - program bit
//   sig    - signal bit, shifted in every clock
//   out    - pattern register equals signal window
module decoder512 #(
    parameter int LEN = 512
) (
    input  logic clk,
    input  logic clr,
    input  logic enable,
    input  logic prgm,
    input  logic sig,
    output logic out
);

    logic [LEN-1:0] pat_reg;
    logic [LEN-1:0] sig_reg;

    // Both registers shift toward the MSB, so the first bit in ends at LEN-1.
    always_ff @(posedge clk) begin
        if (clr) begin
            pat_reg <= '0;
            sig_reg <= '0;
        end else begin
            if (enable) begin
                pat_reg <= {pat_reg[LEN-2:0], prgm};
            end
            sig_reg <= {sig_reg[LEN-2:0], sig};
        end
    end

    assign out = (pat_reg == sig_reg);

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear.
// Latency: count updates one clock after inc.
// Backpressure: none; clr wins over a concurrent inc.
//
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear, result is 0 even if inc is high
//   inc  - add one this cycle unless already saturated
//   cnt  - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/decoder_seq_ctrl.sv
// Sequences a decoder512: clear, serial program load, then armed match detection and counting.
// Latency: match is registered one clock after dec_out; match_cnt one clock after match.
// Backpressure: prg_ready high only in PROGRAM; program bits wait on prg_valid with no timeout.
//
// Build option: define NONOVERLAP_MATCH_EN to suppress matches for LEN-1 DETECT cycles
// after each reported match, so only non-overlapping occurrences are reported and counted.
//
// Ports:
//   clk, clr              - clock and synchronous active-high reset
//   start, abort          - (re)program request; cancel and clear the decoder
//   prg_valid/prg_bit     - program bit stream, accepted when prg_ready=1
//   prg_ready             - controller takes a program bit this cycle
//   sig_in                - serial signal stream, forwarded to the decoder every clock
//   cnt_clr               - zero match_cnt
//   dec_clr/dec_enable/dec_prgm/dec_sig/dec_out - decoder pins
//   busy/armed            - state != IDLE; state == DETECT
//   match/match_cnt       - registered match pulse; saturating match count
module decoder_seq_ctrl
    import decoder_ctrl_pkg::*;
#(
    parameter int LEN   = DEF_LEN,
    parameter int CNT_W = DEF_CNT_W,
    parameter int BC_W  = DEF_BC_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic             prg_valid,
    input  logic             prg_bit,
    output logic             prg_ready,
    input  logic             sig_in,
    input  logic             cnt_clr,
    output logic             dec_clr,
    output logic             dec_enable,
    output logic             dec_prgm,
    output logic             dec_sig,
    input  logic             dec_out,
    output logic             busy,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(LEN - 1);

    ctrl_state_t     state;
    ctrl_state_t     next_state;
    logic            via_abort;   // current CLEAR visit was caused by abort -> return to IDLE
    logic [BC_W-1:0] bit_cnt;
    logic            accept;
    logic            stay_detect;
    logic            match_nxt;

    assign accept      = prg_valid & prg_ready;
    assign stay_detect = (state == DETECT) && (next_state == DETECT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            via_abort <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == CLEAR) begin
                via_abort <= abort;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort outranks start everywhere it applies
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (abort) begin
                    next_state = CLEAR;
                end else if (via_abort) begin
                    next_state = IDLE;
                end else begin
                    next_state = PROGRAM;
                end
            end
            PROGRAM: begin
                // start is deliberately ignored while loading
                if (abort) begin
                    next_state = CLEAR;
                end else if (accept && (bit_cnt == LAST_BIT)) begin
                    next_state = DETECT;
                end
            end
            DETECT: begin
                if (abort || start) begin
                    next_state = CLEAR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs; gated by clr so they read as reset values during reset
    // ------------------------------------------------------------------
    always_comb begin
        prg_ready  = 1'b0;
        busy       = 1'b0;
        armed      = 1'b0;
        dec_clr    = clr | (state == CLEAR);
        dec_prgm   = prg_bit;
        dec_sig    = sig_in;
        if (!clr) begin
            prg_ready = (state == PROGRAM);
            busy      = (state != IDLE);
            armed     = (state == DETECT);
        end
        dec_enable = prg_valid & prg_ready;
    end

    // ------------------------------------------------------------------
    // Program bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt <= '0;
        end else if (state == CLEAR) begin
            bit_cnt <= '0;
        end else if ((state == PROGRAM) && accept) begin
            bit_cnt <= bit_cnt + BC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Match qualification. A match seen on the cycle DETECT is left is
    // dropped so match never shows up outside DETECT.
    // ------------------------------------------------------------------
`ifdef NONOVERLAP_MATCH_EN
    logic [BC_W-1:0] holdoff;

    assign match_nxt = stay_detect && dec_out && (holdoff == '0);

    // Loaded together with the match pulse, so the next report is LEN cycles later.
    always_ff @(posedge clk) begin
        if (clr) begin
            holdoff <= '0;
        end else if (next_state != DETECT) begin
            holdoff <= '0;
        end else if (match_nxt) begin
            holdoff <= LAST_BIT;
        end else if (holdoff != '0) begin
            holdoff <= holdoff - BC_W'(1);
        end
    end
`else
    assign match_nxt = stay_detect && dec_out;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            match <= 1'b0;
        end else begin
            match <= match_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .clr (clr | cnt_clr),
        .inc (match),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_decoder_seq_ctrl.sv
module tb_decoder_seq_ctrl;

    localparam int LEN = 512;

    logic clk = 1'b0;
    logic clr, start, abort, prg_valid, prg_bit, sig_in, cnt_clr;

    logic        prg_ready, dec_clr, dec_enable, dec_prgm, dec_sig, dec_out;
    logic        busy, armed, match;
    logic [15:0] match_cnt;

    logic        prg_ready2, dec_clr2, dec_enable2, dec_prgm2, dec_sig2, dec_out2;
    logic        busy2, armed2, match2;
    logic [1:0]  match_cnt2;

    always #5 clk = ~clk;

    decoder_seq_ctrl #(.LEN(LEN), .CNT_W(16), .BC_W(10)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .prg_valid(prg_valid), .prg_bit(prg_bit), .prg_ready(prg_ready),
        .sig_in(sig_in), .cnt_clr(cnt_clr),
        .dec_clr(dec_clr), .dec_enable(dec_enable), .dec_prgm(dec_prgm),
        .dec_sig(dec_sig), .dec_out(dec_out),
        .busy(busy), .armed(armed), .match(match), .match_cnt(match_cnt)
    );

    decoder512 #(.LEN(LEN)) u_dec (
        .clk(clk), .clr(dec_clr), .enable(dec_enable), .prgm(dec_prgm),
        .sig(dec_sig), .out(dec_out)
    );

    // Narrow-counter copy fed with identical stimulus, for saturation.
    decoder_seq_ctrl #(.LEN(LEN), .CNT_W(2), .BC_W(10)) dut2 (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .prg_valid(prg_valid), .prg_bit(prg_bit), .prg_ready(prg_ready2),
        .sig_in(sig_in), .cnt_clr(cnt_clr),
        .dec_clr(dec_clr2), .dec_enable(dec_enable2), .dec_prgm(dec_prgm2),
        .dec_sig(dec_sig2), .dec_out(dec_out2),
        .busy(busy2), .armed(armed2), .match(match2), .match_cnt(match_cnt2)
    );

    decoder512 #(.LEN(LEN)) u_dec2 (
        .clk(clk), .clr(dec_clr2), .enable(dec_enable2), .prgm(dec_prgm2),
        .sig(dec_sig2), .out(dec_out2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_clr = 0, n_en = 0, n_gap_en = 0, n_match = 0;
    logic gap_now = 1'b0;

    // Reference model state
    logic [LEN-1:0] exp_pat = '0;   // expected decoder pattern register
    logic [LEN-1:0] tb_win  = '0;   // last LEN driven signal bits
    logic           model_on = 1'b0;
    int             next_ok  = 0;
    int             exp_q[$];       // cycles at which match must be high

`ifdef NONOVERLAP_MATCH_EN
    localparam int EXP_OVERLAP = 1;
    localparam int EXP_TOTAL   = 5;
`else
    localparam int EXP_OVERLAP = 9;
    localparam int EXP_TOTAL   = 13;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; update the match model.
    task automatic drive(input logic st, input logic ab, input logic pv, input logic pb,
                         input logic sg, input logic cc, input logic gp);
        @(posedge clk);
        #1;
        start = st; abort = ab; prg_valid = pv; prg_bit = pb;
        sig_in = sg; cnt_clr = cc; gap_now = gp;
        tb_win = {tb_win[LEN-2:0], sg};
        if (model_on && (tb_win == exp_pat) && (cyc >= next_ok)) begin
            // window completes at the next edge, dec_out next cycle, match the one after
            exp_q.push_back(cyc + 2);
`ifdef NONOVERLAP_MATCH_EN
            next_ok = cyc + LEN;
`endif
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Feed LEN program bits (pat[LEN-1] first); optional gap every 3rd cycle.
    task automatic program_pat(input logic [LEN-1:0] pat, input logic gaps);
        int   acc;
        int   k;
        logic gp;
        acc = 0;
        k   = 0;
        exp_pat = pat;
        while (acc < LEN && k < 3 * LEN) begin
            gp = gaps && (k % 3 == 2);
            drive(1'b0, 1'b0, !gp, pat[LEN-1-acc], 1'b0, 1'b0, gp);
            sample();
            if (!gp && prg_ready) begin
                acc++;
                if (acc == LEN) chk("armed_on_last_accept", armed, 0);
            end
            k++;
        end
        if (acc != LEN) chk("program_accept_budget", acc, LEN);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LEN-1:0] pat_alt;
        logic [LEN-1:0] pat_ones;
        int b_clr, b_en, b_gap, b_m, acc, k, e;

        pat_alt  = {256{2'b10}};
        pat_ones = '1;
        clr = 1'b1; start = 1'b0; abort = 1'b0; prg_valid = 1'b0;
        prg_bit = 1'b0; sig_in = 1'b0; cnt_clr = 1'b0;

        // Monitor: event counters and the match scoreboard
        fork
            forever begin
                @(negedge clk);
                if (dec_clr) n_clr++;
                if (dec_enable) n_en++;
                if (dec_enable && gap_now) n_gap_en++;
                if (!clr && match) begin
                    n_match++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL match_unexpected actual=pulse at cycle %0d required=no pulse", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("match_cycle", cyc, e);
                    end
                end
            end
        join_none

        // Reset held three cycles
        repeat (3) begin
            sample();
            chk("rst_dec_clr", dec_clr, 1);
            chk("rst_busy", busy, 0);
            chk("rst_match_cnt", match_cnt, 0);
            chk("rst_prg_ready", prg_ready, 0);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        sample();
        chk("idle_dec_clr", dec_clr, 0);
        chk("idle_busy", busy, 0);
        chk("idle_armed", armed, 0);

        // abort in IDLE is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        idle(1);
        sample();
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_dec_clr", dec_clr, 0);

        // Program alternating pattern, no gaps
        b_clr = n_clr; b_en = n_en;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        program_pat(pat_alt, 1'b0);
        idle(1);
        sample();
        chk("prog_armed", armed, 1);
        chk("prog_ready_in_detect", prg_ready, 0);
        chk("prog_dec_clr_cycles", n_clr - b_clr, 1);
        chk("prog_enable_cycles", n_en - b_en, LEN);

        // Replay the pattern once
        model_on = 1'b1;
        next_ok  = 0;
        for (int i = 0; i < LEN; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, pat_alt[LEN-1-i], 1'b0, 1'b0);
        sample();
        chk("replay_dec_out_before", dec_out, 0);
        idle(1);
        sample();
        chk("replay_dec_out", dec_out, 1);
        chk("replay_match_lag", match, 0);
        idle(1);
        sample();
        chk("replay_match", match, 1);
        idle(20);
        sample();
        chk("replay_match_cnt", match_cnt, 1);
        chk("replay_match_cnt2", match_cnt2, 1);
        model_on = 1'b0;

        // Re-program from DETECT with gaps every third cycle
        b_clr = n_clr; b_en = n_en; b_gap = n_gap_en;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        program_pat(pat_alt, 1'b1);
        idle(1);
        sample();
        chk("gap_armed", armed, 1);
        chk("gap_dec_clr_cycles", n_clr - b_clr, 1);
        chk("gap_enable_cycles", n_en - b_en, LEN);
        chk("gap_enable_on_gap", n_gap_en - b_gap, 0);
        chk("gap_match_cnt_kept", match_cnt, 1);

        // All-ones pattern, long run of ones
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        program_pat(pat_ones, 1'b0);
        idle(1);
        sample();
        chk("ones_armed", armed, 1);
        model_on = 1'b1;
        next_ok  = 0;
        b_m = n_match;
        repeat (520) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        sample();
        chk("overlap_pulses", n_match - b_m, EXP_OVERLAP);

        // Three separated full windows drive the narrow counter into saturation
        repeat (3) begin
            repeat (LEN) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        idle(2);
        sample();
        chk("total_match_cnt", match_cnt, EXP_TOTAL);
        chk("sat_match_cnt2", match_cnt2, 3);

        // cnt_clr in the same cycle as a match pulse
        repeat (LEN) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sample();
        chk("clr_concurrent_match", match, 1);
        idle(1);
        sample();
        chk("clr_match_cnt", match_cnt, 0);
        chk("clr_match_cnt2", match_cnt2, 0);
        idle(2);
        model_on = 1'b0;

        // Abort after 100 accepted bits; a start at bit 50 must be ignored
        b_clr = n_clr;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        acc = 0;
        k   = 0;
        while (acc < 100 && k < 300) begin
            drive(acc == 50, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            sample();
            if (prg_ready) acc++;
            k++;
        end
        chk("abort_accepts", acc, 100);
        chk("abort_still_prog", prg_ready, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sample();
        chk("abort_cycle_dec_clr", dec_clr, 0);
        idle(1);
        sample();
        chk("abort_clear_dec_clr", dec_clr, 1);
        chk("abort_clear_ready", prg_ready, 0);
        idle(1);
        sample();
        chk("abort_idle_dec_clr", dec_clr, 0);
        chk("abort_idle_busy", busy, 0);
        chk("abort_dec_clr_cycles", n_clr - b_clr, 2);

        chk("pending_matches", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
